pc_unit: RTL and testbench

- 16-bit program counter for the Hack-style CPU datapath.
- Its registered `out` feeds the instruction-address path.
- Its next-value selection (in / out+1 / out) is the sequential stage that the Mux16 and Mux8Way16 select logic drives.
- Adds stall, wrap detection and jump-to-self halt detection.

---
 rtl/pc_unit_pkg.sv | 16 +
 rtl/pc_unit_inc16.sv | 20 ++
 rtl/pc_unit.sv | 164 ++++++++++++++++
 tb/tb_pc_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared constants for the program counter unit: address width,
//               reset vector and return-stack geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int              PC_WIDTH        = 16;
    localparam logic [15:0]     PC_RESET_VECTOR = 16'h0000;
    localparam int              PC_STACK_DEPTH  = 8;
    localparam int              PC_STACK_PTR_W  = 4;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_inc16.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_inc16
// Description : Incrementer for the program counter. Produces a + 1 and the
//               carry-out; the carry-out marks an all-ones to zero rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit_inc16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Widen by one bit so the carry falls out of the addition directly.
    assign {carry_out, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule : pc_unit_inc16
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Registered program counter with stall, increment-wrap pulse
//               and sticky jump-to-self halt detection.
//               Optional macro PC_STACK_EN adds call/ret with an 8-entry
//               return-address LIFO and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             stall,
`ifdef PC_STACK_EN
    input  logic             call,
    input  logic             ret,
    output logic             stk_ovf,
    output logic             stk_unf,
`endif
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             halted
);

    logic [WIDTH-1:0] r_pc;
    logic             r_wrap;
    logic             r_halted;

    logic [WIDTH-1:0] w_inc_sum;
    logic             w_inc_carry;

    logic [WIDTH-1:0] w_next_pc;
    logic             w_next_wrap;
    logic             w_next_halted;

    pc_unit_inc16 #(
        .WIDTH     (WIDTH)
    ) u_inc (
        .a         (r_pc),
        .sum       (w_inc_sum),
        .carry_out (w_inc_carry)
    );

`ifdef PC_STACK_EN
    localparam logic [PC_STACK_PTR_W-1:0] c_STACK_FULL = PC_STACK_PTR_W'(PC_STACK_DEPTH);

    logic [WIDTH-1:0]          r_stack [PC_STACK_DEPTH];
    logic [PC_STACK_PTR_W-1:0] r_depth;
    logic                      r_stk_ovf;
    logic                      r_stk_unf;

    logic [PC_STACK_PTR_W-1:0] w_next_depth;
    logic                      w_next_ovf;
    logic                      w_next_unf;
    logic                      w_push;
    logic [2:0]                w_top_idx;
    logic [2:0]                w_push_idx;

    assign w_top_idx  = 3'(r_depth - 1'b1);
    assign w_push_idx = r_depth[2:0];

    // Next-state selection: stall > ret > call > load > inc > hold.
    always_comb begin
        w_next_pc     = r_pc;
        w_next_wrap   = 1'b0;
        w_next_halted = r_halted;
        w_next_depth  = r_depth;
        w_next_ovf    = r_stk_ovf;
        w_next_unf    = r_stk_unf;
        w_push        = 1'b0;
        if (stall) begin
            // everything holds, wrap drops
        end else if (ret) begin
            if (r_depth == '0) begin
                w_next_unf = 1'b1;
            end else begin
                w_next_pc    = r_stack[w_top_idx];
                w_next_depth = r_depth - 1'b1;
            end
        end else if (call) begin
            w_next_pc     = in;
            w_next_halted = (in == r_pc);
            if (r_depth == c_STACK_FULL) begin
                w_next_ovf = 1'b1;
            end else begin
                w_push       = 1'b1;
                w_next_depth = r_depth + 1'b1;
            end
        end else if (load) begin
            w_next_pc     = in;
            w_next_halted = (in == r_pc);
        end else if (inc) begin
            w_next_pc   = w_inc_sum;
            w_next_wrap = w_inc_carry;
        end
    end

    // Stack bookkeeping; entry contents need no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth   <= '0;
            r_stk_ovf <= 1'b0;
            r_stk_unf <= 1'b0;
        end else begin
            r_depth   <= w_next_depth;
            r_stk_ovf <= w_next_ovf;
            r_stk_unf <= w_next_unf;
        end
    end

    // Return-address write: the pushed value is the wrapped out+1.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_stack[w_push_idx] <= w_inc_sum;
        end
    end

    assign stk_ovf = r_stk_ovf;
    assign stk_unf = r_stk_unf;
`else
    // Next-state selection: stall > load > inc > hold.
    always_comb begin
        w_next_pc     = r_pc;
        w_next_wrap   = 1'b0;
        w_next_halted = r_halted;
        if (stall) begin
            // everything holds, wrap drops
        end else if (load) begin
            w_next_pc     = in;
            w_next_halted = (in == r_pc);
        end else if (inc) begin
            w_next_pc   = w_inc_sum;
            w_next_wrap = w_inc_carry;
        end
    end
`endif

    // PC and flag registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_VECTOR;
            r_wrap   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_next_pc;
            r_wrap   <= w_next_wrap;
            r_halted <= w_next_halted;
        end
    end

    assign out    = r_pc;
    assign wrap   = r_wrap;
    assign halted = r_halted;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        stall;
    logic [15:0] out;
    logic        wrap;
    logic        halted;

    int r_checks = 0;
    int r_errors = 0;

    pc_unit u_dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .load   (load),
        .inc    (inc),
        .stall  (stall),
        .out    (out),
        .wrap   (wrap),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        r_checks++;
        if (obs !== exp_val) begin
            r_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_val);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic l, input logic i,
                         input logic [15:0] d);
        reset = r;
        stall = s;
        load  = l;
        inc   = i;
        in    = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);

        // Reset beats a simultaneous load
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
        step();
        check("rst_out",    out,    16'h0000);
        check("rst_wrap",   wrap,   1'b0);
        check("rst_halted", halted, 1'b0);

        // Five increments from zero
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        for (int k = 0; k < 5; k++) step();
        check("inc5_out", out, 16'h0005);

        // Load wins over inc
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0100);
        step();
        check("ld_inc_out",    out,    16'h0100);
        check("ld_inc_halted", halted, 1'b0);

        // Hold when neither load nor inc
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0300);
        step();
        check("hold_out", out, 16'h0100);

        // Wrap from all-ones
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        step();
        check("ldff_out",  out,  16'hFFFF);
        check("ldff_wrap", wrap, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("wrap_out",   out,  16'h0000);
        check("wrap_pulse", wrap, 1'b1);
        step();
        check("post_wrap_out",  out,  16'h0001);
        check("post_wrap_wrap", wrap, 1'b0);

        // Load of zero from all-ones is not a wrap
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        check("ld0_out",  out,  16'h0000);
        check("ld0_wrap", wrap, 1'b0);

        // Stall freezes the PC for several edges despite load
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0500);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_out", out, 16'h0010);
        end
        check("stall_wrap", wrap, 1'b0);

        // Reset beats stall
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0500);
        step();
        check("rst_stall_out", out, 16'h0000);

        // Halt detection
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0042);
        step();
        check("pre_halt_out",    out,    16'h0042);
        check("pre_halt_halted", halted, 1'b0);
        step();
        check("halt_set", halted, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("halt_inc_out",    out,    16'h0043);
        check("halt_inc_halted", halted, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0007);
        step();
        check("halt_stall_halted", halted, 1'b1);
        check("halt_stall_out",    out,    16'h0043);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0007);
        step();
        check("halt_clr_out",    out,    16'h0007);
        check("halt_clr_halted", halted, 1'b0);

        // Halt again, then reset clears it
        step();
        check("halt_again", halted, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("halt_rst_halted", halted, 1'b0);
        check("halt_rst_out",    out,    16'h0000);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
